// File: rtl/rom_pkg.sv
// Shared definitions for the two-requester ROM read arbiter: geometry,
// requester IDs and the tag that travels alongside each outstanding read.
package rom_pkg;

  localparam int ROM_ADDR_W = 14;
  localparam int ROM_DATA_W = 24;
  localparam int ROM_LAT    = 1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Requester ID owning a one-hot (or zero) grant vector.
  function automatic logic grant_id(input logic [1:0] grant);
    return grant[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Bundle of requester handshakes and ROM pins seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface rom_read_arbiter_if
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_enable;
  logic [DATA_W-1:0] rom_data_out;

  logic              idle;

  modport slave (
    input  req0, addr0, req1, addr1, rom_data_out,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output rom_address, rom_read_enable, idle
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data_out,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  rom_address, rom_read_enable, idle
  );

endinterface

// File: rtl/rom_read_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant from the effective
// requests, plus a flop remembering who won the last grant.
module rr_arb2
  import rom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eff_req,
  output logic [1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = 2'b00;
    unique case (eff_req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   grant = (last_reg == REQ0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= REQ1;
    end else if (|grant) begin
      last_reg <= grant_id(grant);
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous ROM between two requesters: registered issue stage,
// a {valid,id} tag pipeline matching the ROM latency, and per-requester returns.
module rom_read_arbiter
  import rom_pkg::tag_t, rom_pkg::grant_id;
#(
  parameter int ADDR_W  = rom_pkg::ROM_ADDR_W,
  parameter int DATA_W  = rom_pkg::ROM_DATA_W,
  parameter int ROM_LAT = rom_pkg::ROM_LAT
)(
  input logic                clk,
  input logic                rst,
  rom_read_arbiter_if.slave  bus
);

  logic [1:0]        req;
  logic [1:0]        eff_req;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] addr [2];

  logic [1:0]        gnt_reg;
  logic              rom_read_enable_reg;
  logic [ADDR_W-1:0] rom_address_reg;

  tag_t              tag_pipe_reg [ROM_LAT+1];
  logic [ROM_LAT:0]  tag_valid;
  tag_t              mature;

  assign req     = {bus.req1, bus.req0};
  assign addr[0] = bus.addr0;
  assign addr[1] = bus.addr1;

  // A requester is masked during its own grant cycle so a held req yields
  // one read every other cycle instead of back-to-back duplicates.
  assign eff_req = req & ~gnt_reg;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .eff_req (eff_req),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg             <= '0;
      rom_read_enable_reg <= 1'b0;
      rom_address_reg     <= '0;
    end else begin
      gnt_reg             <= grant;
      rom_read_enable_reg <= |grant;
      if (|grant) begin
        rom_address_reg <= grant[1] ? addr[1] : addr[0];
      end
    end
  end

  // Stage 0 is loaded with the issue; stage ROM_LAT lines up with valid ROM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_pipe_reg[i] <= '0;
      end
    end else begin
      tag_pipe_reg[0].valid <= |grant;
      tag_pipe_reg[0].id    <= grant_id(grant);
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
    end
  end

  assign mature = tag_pipe_reg[ROM_LAT];

  for (genvar gi = 0; gi <= ROM_LAT; gi++) begin : g_tag_valid
    assign tag_valid[gi] = tag_pipe_reg[gi].valid;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              hit;

    assign hit = mature.valid && (mature.id == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= hit;
        if (hit) begin
          rdata_reg <= bus.rom_data_out;
        end
      end
    end
  end

  assign bus.gnt0            = gnt_reg[0];
  assign bus.gnt1            = gnt_reg[1];
  assign bus.rvalid0         = g_ret[0].rvalid_reg;
  assign bus.rvalid1         = g_ret[1].rvalid_reg;
  assign bus.rdata0          = g_ret[0].rdata_reg;
  assign bus.rdata1          = g_ret[1].rdata_reg;
  assign bus.rom_address     = rom_address_reg;
  assign bus.rom_read_enable = rom_read_enable_reg;
  assign bus.idle            = ~|tag_valid & ~rom_read_enable_reg;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed scenarios plus a random phase, all checked every cycle against a
// transaction-level model (grant choice, fixed return latency, memory[i]=i).
module tb_rom_read_arbiter;
  import rom_pkg::*;

  localparam int AW = ROM_ADDR_W;
  localparam int DW = ROM_DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_read_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM preloaded with memory[i]=i, one-cycle registered read.
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
  always @(posedge clk) if (bus.rom_read_enable) bus.rom_data_out <= mem[bus.rom_address];

  typedef struct {
    int          id;
    logic [AW-1:0] addr;
    int          age;
  } txn_t;

  txn_t          pend[$];
  logic [1:0]    m_gnt;
  logic [1:0]    m_rvalid;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata [2];
  int            m_last;

  int errors = 0;
  int checks = 0;
  int n_gnt0, n_gnt1, n_rv0, n_rv1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [1:0] eff;
    int pick;
    if (rst) begin
      m_gnt = '0; m_rvalid = '0; m_en = 1'b0; m_addr = '0;
      m_rdata[0] = '0; m_rdata[1] = '0;
      m_last = 1;
      pend.delete();
      return;
    end
    m_rvalid = '0;
    foreach (pend[i]) pend[i].age++;
    // A read decided at edge E returns at edge E+2.
    if (pend.size() > 0 && pend[0].age == 2) begin
      txn_t t;
      t = pend.pop_front();
      m_rvalid[t.id] = 1'b1;
      m_rdata[t.id]  = DW'(t.addr);
    end
    eff  = {bus.req1, bus.req0} & ~m_gnt;
    pick = -1;
    if (eff == 2'b11)  pick = (m_last == 0) ? 1 : 0;
    else if (eff[0])   pick = 0;
    else if (eff[1])   pick = 1;
    m_gnt = '0;
    m_en  = 1'b0;
    if (pick >= 0) begin
      m_gnt[pick] = 1'b1;
      m_en        = 1'b1;
      m_addr      = (pick == 1) ? bus.addr1 : bus.addr0;
      m_last      = pick;
      pend.push_back('{id: pick, addr: m_addr, age: 0});
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ".gnt"},    32'({bus.gnt1, bus.gnt0}),       32'(m_gnt));
    chk({step, ".rvalid"}, 32'({bus.rvalid1, bus.rvalid0}), 32'(m_rvalid));
    chk({step, ".ren"},    32'(bus.rom_read_enable),        32'(m_en));
    chk({step, ".raddr"},  32'(bus.rom_address),            32'(m_addr));
    chk({step, ".idle"},   32'(bus.idle),                   32'(pend.size() == 0 && !m_en));
    chk({step, ".rdata0"}, 32'(bus.rdata0),                 32'(m_rdata[0]));
    chk({step, ".rdata1"}, 32'(bus.rdata1),                 32'(m_rdata[1]));
    if (bus.gnt0 === 1'b1)    n_gnt0++;
    if (bus.gnt1 === 1'b1)    n_gnt1++;
    if (bus.rvalid0 === 1'b1) n_rv0++;
    if (bus.rvalid1 === 1'b1) n_rv1++;
    $display("%s t=%0t gnt=%b rv=%b ren=%b addr=%0d rd0=%h rd1=%h idle=%b",
             step, $time, {bus.gnt1, bus.gnt0}, {bus.rvalid1, bus.rvalid0},
             bus.rom_read_enable, bus.rom_address, bus.rdata0, bus.rdata1, bus.idle);
  endtask

  task automatic tick(input string step);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(step);
  endtask

  task automatic clear_counts();
    n_gnt0 = 0; n_gnt1 = 0; n_rv0 = 0; n_rv1 = 0;
  endtask

  initial begin
    m_gnt = '0; m_rvalid = '0; m_en = 1'b0; m_addr = '0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;
    clear_counts();

    // 1: reset with requests held high
    rst = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = '0;
    bus.req1 = 1'b1; bus.addr1 = '0;
    tick("t1"); tick("t1");
    chk("t1.idle_const", 32'(bus.idle), 32'd1);
    chk("t1.ren_const",  32'(bus.rom_read_enable), 32'd0);
    rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick("t1");

    // 2: single read near the top of the address space
    clear_counts();
    bus.req0 = 1'b1; bus.addr0 = AW'(16368);
    tick("t2");
    bus.req0 = 1'b0;
    repeat (4) tick("t2");
    chk("t2.rv0_count", 32'(n_rv0), 32'd1);
    chk("t2.rv1_count", 32'(n_rv1), 32'd0);
    chk("t2.rdata0",    32'(bus.rdata0), 32'h003FF0);

    // 3: both requesters held -> alternating grants
    clear_counts();
    bus.req0 = 1'b1; bus.addr0 = AW'(10);
    bus.req1 = 1'b1; bus.addr1 = AW'(20);
    repeat (8) tick("t3");
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) tick("t3");
    chk("t3.gnt0_count", 32'(n_gnt0), 32'd4);
    chk("t3.gnt1_count", 32'(n_gnt1), 32'd4);
    chk("t3.rdata0", 32'(bus.rdata0), 32'h00000A);
    chk("t3.rdata1", 32'(bus.rdata1), 32'h000014);

    // 4: requester 1 alone, then requester 0 joins
    clear_counts();
    bus.req1 = 1'b1; bus.addr1 = AW'(7);
    repeat (5) tick("t4");
    bus.req0 = 1'b1; bus.addr0 = AW'(3);
    repeat (11) tick("t4");
    chk("t4.no_starve0", 32'(n_gnt0 > 0), 32'd1);
    chk("t4.no_starve1", 32'(n_gnt1 > 0), 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) tick("t4");

    // 5: reset lands while a read is in flight
    clear_counts();
    bus.req0 = 1'b1; bus.addr0 = AW'(5);
    tick("t5");
    bus.req0 = 1'b0;
    tick("t5");
    rst = 1'b1;
    tick("t5");
    chk("t5.idle_after_rst", 32'(bus.idle), 32'd1);
    rst = 1'b0;
    repeat (4) tick("t5");
    chk("t5.rv0_count", 32'(n_rv0), 32'd0);

    // 6: address sweep on requester 1
    clear_counts();
    for (int a = 16368; a <= 16383; a++) begin
      bus.req1 = 1'b1; bus.addr1 = AW'(a);
      tick("t6");
      bus.req1 = 1'b0;
      tick("t6");
    end
    repeat (4) tick("t6");
    chk("t6.rv1_count", 32'(n_rv1), 32'd16);
    chk("t6.rdata1_top", 32'(bus.rdata1), 32'h003FFF);

    // Random phase
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.addr0 = AW'($urandom);
      bus.addr1 = AW'($urandom);
      tick("rnd");
    end
    rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) tick("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
